inst_ram_loader: RTL

Byte-stream program loader for the one-port instruction BRAM. It takes a framed byte stream from a host link (UART receiver or testbench), writes each payload byte into consecutive instruction-RAM byte addresses, and verifies an 8-bit checksum. It holds the RV32I core in reset until a frame loads successfully. It owns the RAM write side (`en`, `we`, `addr`, `din`) during loading; the core's fetch path uses the same RAM through an external mux selected by `core_rst`.

---
 rtl/inst_ram_loader_pkg.sv | 19 +
 rtl/inst_ram_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/inst_ram_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-RAM byte-stream loader.
// Imported by the loader RTL; the bench uses the same values.
package inst_ram_loader_pkg;

  localparam int         INST_DEPTH_DEF = 1024;
  localparam int         INST_MEM_WIDTH = 32;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/inst_ram_loader.sv
// Framed byte-stream loader: SYNC, LEN_LO, LEN_HI, N payload bytes, 8-bit sum.
// Writes payload to consecutive RAM bytes and releases core_rst only on a good frame.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int         INST_DEPTH = INST_DEPTH_DEF,
  parameter int         ADDR_W     = $clog2(INST_DEPTH),
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_en,
  output logic              mem_we,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0] DEPTH_LIMIT = 17'(INST_DEPTH);

  ldr_state_e        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [7:0]        r_sum;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_din;
  logic              r_mem_en;
  logic              r_core_rst;
  logic              r_load_done;
  logic              r_load_err;

  logic              w_is_sync;
  logic [15:0]       w_len;
  logic [15:0]       w_cnt_next;
  logic [7:0]        w_sum_next;

  always_comb begin
    w_is_sync  = (rx_data == SYNC_BYTE);
    w_len      = {rx_data, r_len[7:0]};
    w_cnt_next = r_cnt + 16'd1;
    w_sum_next = r_sum + rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_en    <= 1'b0;
      r_core_rst  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      // Write strobe is a one-cycle pulse per accepted payload byte.
      r_mem_en <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (w_is_sync) begin
              r_state     <= ST_LEN0;
              r_core_rst  <= 1'b1;
              r_load_done <= 1'b0;
              r_load_err  <= 1'b0;
              r_cnt       <= '0;
              r_sum       <= '0;
            end
          end
          ST_LEN0: begin
            r_len[7:0] <= rx_data;
            r_state    <= ST_LEN1;
          end
          ST_LEN1: begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
              r_state <= ST_CHK;
            end else if ({1'b0, w_len} > DEPTH_LIMIT) begin
              // Reject before any write so an oversized image cannot wrap the RAM.
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_cnt[ADDR_W-1:0];
            r_mem_din  <= rx_data;
            r_sum      <= w_sum_next;
            r_cnt      <= w_cnt_next;
            if (w_cnt_next == r_len) begin
              r_state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (rx_data == r_sum) begin
              r_state     <= ST_DONE;
              r_load_done <= 1'b1;
              r_core_rst  <= 1'b0;
            end else begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_en;
  assign core_rst  = r_core_rst;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule
